updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with run/halt control, synchronous clear/load and a
// registered terminal-count pulse; range is 0..max_val inclusive.
module updown_mod_counter #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             done
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZeroVal = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic             at_bottom;
    logic             at_top;
    logic             step_en;
    logic             terminal;

    assign at_bottom = (q_q == ZeroVal);
    // Counts above max_val (after max_val shrinks) are treated as terminal going up.
    assign at_top    = (q_q >= max_val);
    assign step_en   = (state_q == StRun) && en && !clr && !load;
    assign terminal  = step_en && ((up && at_top) || (!up && at_bottom));

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (clr) begin
            q_d     = up ? ZeroVal : max_val;
            state_d = StRun;
            done_d  = 1'b0;
        end else if (load) begin
            q_d     = (load_val > max_val) ? max_val : load_val;
            state_d = StRun;
            done_d  = 1'b0;
        end else if (terminal) begin
            tc_d = 1'b1;
            if (one_shot) begin
                state_d = StHalt;
                done_d  = 1'b1;
            end else begin
                q_d = up ? ZeroVal : max_val;
            end
        end else if (step_en) begin
            if (up) begin
                q_d = q_q + OneVal;
            end else if (q_q > max_val) begin
                q_d = max_val;
            end else begin
                q_d = q_q - OneVal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RST_VAL;
            state_q <= StRun;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule
